// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin merge of NUM_INPUTS AXI-Stream queues onto one registered output.
// Define FULLNESS_PRIORITY_EN to restrict arbitration to half-full queues whenever any are valid.
module axis_packet_arbiter #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEST_WIDTH = 4,
    localparam int unsigned IdxW = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_tdata,
    input  logic [NUM_INPUTS*DEST_WIDTH-1:0] in_tdest,
    input  logic [NUM_INPUTS-1:0]            in_tlast,
    input  logic [NUM_INPUTS-1:0]            in_tvalid,
    output logic [NUM_INPUTS-1:0]            in_tready,
    input  logic [NUM_INPUTS-1:0]            in_half_full,
    output logic [DATA_WIDTH-1:0]            out_tdata,
    output logic [DEST_WIDTH-1:0]            out_tdest,
    output logic                             out_tlast,
    output logic                             out_tvalid,
    input  logic                             out_tready,
    output logic [IdxW-1:0]                  grant_idx,
    output logic                             busy
);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         grant_q, grant_d;
    logic [IdxW-1:0]         last_q, last_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [DEST_WIDTH-1:0]   tdest_q, tdest_d;
    logic                    tlast_q, tlast_d;
    logic                    tvalid_q, tvalid_d;

    logic [NUM_INPUTS-1:0]   req;
    logic [IdxW-1:0]         pick;
    logic                    pick_found;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [DEST_WIDTH-1:0]   sel_dest;
    logic                    sel_last;
    logic                    sel_valid;
    logic                    adv;
    logic                    accept;

`ifdef FULLNESS_PRIORITY_EN
    logic [NUM_INPUTS-1:0] urgent;
    assign urgent = in_tvalid & in_half_full;
    assign req    = (|urgent) ? urgent : in_tvalid;
`else
    logic unused_half_full;
    assign unused_half_full = ^in_half_full;
    assign req              = in_tvalid;
`endif

    // First requester in circular order starting just after the last grant.
    always_comb begin
        int unsigned cand;
        logic [IdxW-1:0] cand_idx;
        cand       = 0;
        cand_idx   = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
            cand     = (32'(last_q) + k) % NUM_INPUTS;
            cand_idx = IdxW'(cand);
            if (!pick_found && req[cand_idx]) begin
                pick       = cand_idx;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_dest  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (grant_q == IdxW'(i)) begin
                sel_data  = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_dest  = in_tdest[i*DEST_WIDTH +: DEST_WIDTH];
                sel_last  = in_tlast[i];
                sel_valid = in_tvalid[i];
            end
        end
    end

    assign adv    = !tvalid_q || out_tready;
    assign accept = (state_q == StLocked) && sel_valid && adv;

    always_comb begin
        in_tready = '0;
        if (state_q == StLocked) begin
            in_tready[grant_q] = adv;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        tdata_d  = tdata_q;
        tdest_d  = tdest_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        if (tvalid_q && out_tready) begin
            tvalid_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick;
                    last_d  = pick;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                // Grant is held through bubbles until the TLAST beat is taken.
                if (accept) begin
                    tvalid_d = 1'b1;
                    tdata_d  = sel_data;
                    tdest_d  = sel_dest;
                    tlast_d  = sel_last;
                    if (sel_last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            last_q   <= IdxW'(NUM_INPUTS - 1);
            tdata_q  <= '0;
            tdest_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            tdata_q  <= tdata_d;
            tdest_q  <= tdest_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign out_tdata  = tdata_q;
    assign out_tdest  = tdest_q;
    assign out_tlast  = tlast_q;
    assign out_tvalid = tvalid_q;
    assign grant_idx  = grant_q;
    assign busy       = (state_q == StLocked);

endmodule
